// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one load/store at a time over a req/ack handshake,
// WAIT_STATES cycles of latency, byte-lane store merge and alignment/range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        counter;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic              bad;
    logic              entering_resp;
    logic [IDX_W-1:0]  idx;

    // With zero wait states RESP is entered on the sampling edge itself, so the
    // live inputs stand in for the latched request while idle.
    always_comb begin
        cur_we        = (state == S_IDLE) ? we    : we_q;
        cur_addr      = (state == S_IDLE) ? addr  : addr_q;
        cur_wdata     = (state == S_IDLE) ? wdata : wdata_q;
        cur_be        = (state == S_IDLE) ? be    : be_q;
        bad           = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_LIMIT);
        idx           = cur_addr[IDX_W+1:2];
        entering_resp = (state_next == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (counter == 4'd1) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == S_RESP);
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
                counter <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                counter <= counter - 4'd1;
            end
            if (entering_resp) begin
                err   <= bad;
                rdata <= (!bad && !cur_we) ? mem[idx] : '0;
            end else if (state == S_RESP) begin
                err   <= 1'b0;
                rdata <= '0;
            end
        end
    end

    // Stores commit only on entry to RESP, so a reset during WAIT drops them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (entering_resp && cur_we && !bad) begin
            for (int l = 0; l < 4; l++)
                if (cur_be[l]) mem[idx][8*l +: 8] <= cur_wdata[8*l +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against an array-based memory model.
module tb_dmem_responder;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        ack, err, busy;
    logic [31:0] rdata;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [3:0]  be1 = '0;
    logic        ack1, err1, busy1;
    logic [31:0] rdata1;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy));

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .be(be1), .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1));

    function automatic bit exp_err(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 64);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic w, input logic [31:0] a);
        if (w || exp_err(a)) return 32'h0;
        return ref_mem[a / 4];
    endfunction

    task automatic model_commit(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b);
        if (w && !exp_err(a))
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[a / 4][8*i +: 8] = d[8*i +: 8];
    endtask

    // Drives one transaction starting just after a clock edge with the DUT idle;
    // lat is the number of edges after the sampling edge until ack, -1 on timeout.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] rd, output logic er,
                           output int lat, output logic ack_next);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        rd = '0; er = 1'b0; lat = -1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            if (ack) begin lat = i; rd = rdata; er = err; break; end
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(posedge clk); #1;
        ack_next = ack;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, an; int lat;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({ack, err, busy, rdata} !== 35'h0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs: got ack=%b err=%b busy=%b rdata=%h expected all 0", ack, err, busy, rdata);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 32'h3C, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== WS) begin
            tests_failed++;
            $display("[TB] FAIL reset_load: got rdata=%h err=%b lat=%0d expected 00000000 0 %0d", rd, er, lat, WS);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, an; int lat;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, an);
        model_commit(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tests_run++;
        if (lat !== WS || an !== 1'b0 || er !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL store_timing: got lat=%0d ack_next=%b err=%b rdata=%h expected %0d 0 0 0", lat, an, er, rd, WS);
        end
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (lat !== WS || an !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL load_after_store: got lat=%0d ack_next=%b rdata=%h expected %0d 0 deadbeef", lat, an, rd, WS);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er, an; int lat;
        run_txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat, an);
        model_commit(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        run_txn(1'b1, 32'h10, 32'h11000000, 4'b1000, rd, er, lat, an);
        model_commit(1'b1, 32'h10, 32'h11000000, 4'b1000);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== 32'h11ADBEAA || er !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL byte_lanes: got rdata=%h err=%b expected 11adbeaa 0", rd, er);
        end
        run_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat, an);
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== 32'h11ADBEAA || er !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL be_zero: got rdata=%h err=%b expected 11adbeaa 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, an; int lat;
        logic [31:0] bad_addrs [3] = '{32'h12, 32'h100, 32'h40000010};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, bad_addrs[i], 32'h5A5A5A5A, 4'hF, rd, er, lat, an);
            tests_run++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== WS) begin
                tests_failed++;
                $display("[TB] FAIL err_store %h: got err=%b rdata=%h lat=%0d expected 1 0 %0d", bad_addrs[i], er, rd, lat, WS);
            end
            run_txn(1'b0, bad_addrs[i], 32'h0, 4'h0, rd, er, lat, an);
            tests_run++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                tests_failed++;
                $display("[TB] FAIL err_load %h: got err=%b rdata=%h expected 1 0", bad_addrs[i], er, rd);
            end
        end
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== ref_mem[4] || er !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_no_change: got rdata=%h err=%b expected %h 0", rd, er, ref_mem[4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic er, an, w; logic [3:0] b; int lat, r;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else             a = 32'($urandom_range(0, 63)) * 4;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            run_txn(w, a, d, b, rd, er, lat, an);
            tests_run++;
            if (rd !== exp_rdata(w, a) || er !== exp_err(a) || lat !== WS || an !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL random #%0d we=%b addr=%h: got rdata=%h err=%b lat=%0d ack_next=%b expected %h %b %0d 0",
                         n, w, a, rd, er, lat, an, exp_rdata(w, a), exp_err(a), WS);
            end
            model_commit(w, a, d, b);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] rd; logic er, an; int lat;
        run_txn(1'b1, 32'h10, 32'h01020304, 4'hF, rd, er, lat, an);
        model_commit(1'b1, 32'h10, 32'h01020304, 4'hF);
        run_txn(1'b1, 32'h14, 32'hA0B0C0D0, 4'hF, rd, er, lat, an);
        model_commit(1'b1, 32'h14, 32'hA0B0C0D0, 4'hF);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(posedge clk); #1;
        addr = 32'h14;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (ack) begin lat = i; rd = rdata; break; end
            @(posedge clk); #1;
        end
        tests_run++;
        if (lat !== WS || rd !== ref_mem[4]) begin
            tests_failed++;
            $display("[TB] FAIL hs_orig_addr: got lat=%0d rdata=%h expected %0d %h", lat, rd, WS, ref_mem[4]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hs_idle_gap: got busy=%b ack=%b expected 0 0", busy, ack);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hs_second_start: got busy=%b expected 1", busy);
        end
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (ack) begin lat = i; rd = rdata; break; end
            @(posedge clk); #1;
        end
        req = 1'b0;
        tests_run++;
        if (lat !== WS || rd !== ref_mem[5]) begin
            tests_failed++;
            $display("[TB] FAIL hs_second_txn: got lat=%0d rdata=%h expected %0d %h", lat, rd, WS, ref_mem[5]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hCAFEF00D; be1 = 4'hF;
        @(posedge clk); #1;
        tests_run++;
        if (ack1 !== 1'b1 || err1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ws0_store_ack: got ack=%b err=%b expected 1 0", ack1, err1);
        end
        req1 = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (ack1 !== 1'b1 || rdata1 !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("[TB] FAIL ws0_load: got ack=%b rdata=%h expected 1 cafef00d", ack1, rdata1);
        end
        req1 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (ack1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ws0_ack_pulse: got ack=%b expected 0", ack1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, an; int lat;
        bit seen_ack = 0;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ack) seen_ack = 1;
            @(posedge clk); #1;
        end
        req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (ack) seen_ack = 1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_ack: got ack seen=%b expected 0", seen_ack);
        end
        run_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== WS) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_load: got rdata=%h err=%b lat=%0d expected 0 0 %0d", rd, er, lat, WS);
        end
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_mem: got rdata=%h expected 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_random();
        test_handshake();
        test_zero_wait();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
